// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Optional misalignment check is enabled by defining IMEM_ARB_ALIGN_CHECK_EN.
package imem_arb_pkg;

   localparam int ADDR_W_DEFAULT = 10;
   localparam int WORD_BYTES     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      LAST  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Grant encoding doubles as the bit index into req/gnt vectors.
   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_LOAD  = 1'b1
   } grant_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory port arbiter.
// slave is the arbiter's view; master is the clients' and memory's view.
interface imem_port_arbiter_if
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
);
   logic              fetch_valid;
   logic              fetch_ready;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_rvalid;
   logic [31:0]       fetch_rdata;
   logic              fetch_err;

   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        load_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  fetch_valid, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      output fetch_ready, fetch_rvalid, fetch_rdata, fetch_err, load_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output fetch_valid, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      input  fetch_ready, fetch_rvalid, fetch_rdata, fetch_err, load_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_rr_arb.sv
// Two-way round-robin arbiter: on a tie, grants the requester not granted last.
// Bit 0 is fetch, bit 1 is load; last grant resets to load so fetch wins first.
module imem_rr_arb
   import imem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   grant_t last_grant_reg;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last_grant_reg == GNT_LOAD) ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_reg <= GNT_LOAD;
      end else if (advance && (gnt != 2'b00)) begin
         last_grant_reg <= gnt[0] ? GNT_FETCH : GNT_LOAD;
      end
   end
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the byte-wide instruction memory port between fetch (4-byte big-endian
// reads) and the loader (byte writes). IMEM_ARB_ALIGN_CHECK_EN flags misaligned fetches.
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   imem_port_arbiter_if.slave bus,
   output logic               busy
);
   localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [1:0]        cnt_reg;
   logic [23:0]       acc_reg;
   logic [31:0]       rdata_reg;
   logic              rvalid_reg;
   logic              err_reg;
   logic              misalign_reg;
   logic [7:0]        wdata_reg;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       advance;
   logic       fetch_acc;
   logic       load_acc;
   logic       misalign;

   assign req     = {bus.load_valid, bus.fetch_valid};
   assign advance = (state_reg == IDLE);

   imem_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (advance),
      .gnt     (gnt)
   );

   assign fetch_acc = (state_reg == IDLE) && gnt[0];
   assign load_acc  = (state_reg == IDLE) && gnt[1];

`ifdef IMEM_ARB_ALIGN_CHECK_EN
   assign misalign = (bus.fetch_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      bus.fetch_ready = fetch_acc;
      bus.load_ready  = load_acc;
      bus.mem_en      = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      busy            = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (fetch_acc) begin
               state_next = misalign ? LAST : READ;
            end else if (load_acc) begin
               state_next = WRITE;
            end
         end
         READ: begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = addr_reg + ADDR_W'(cnt_reg);
            if (cnt_reg == LAST_BYTE) begin
               state_next = LAST;
            end
         end
         LAST: begin
            state_next = IDLE;
         end
         WRITE: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = addr_reg;
            bus.mem_wdata = wdata_reg;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Read data trails the issued address by one cycle, so byte k-1 lands while reading k.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg     <= '0;
         cnt_reg      <= '0;
         acc_reg      <= '0;
         rdata_reg    <= '0;
         rvalid_reg   <= 1'b0;
         err_reg      <= 1'b0;
         misalign_reg <= 1'b0;
         wdata_reg    <= '0;
      end else begin
         rvalid_reg <= 1'b0;
         err_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (fetch_acc) begin
                  addr_reg     <= bus.fetch_addr;
                  cnt_reg      <= '0;
                  misalign_reg <= misalign;
               end else if (load_acc) begin
                  addr_reg  <= bus.load_addr;
                  wdata_reg <= bus.load_data;
               end
            end
            READ: begin
               cnt_reg <= cnt_reg + 2'd1;
               if (cnt_reg != 2'd0) begin
                  acc_reg <= {acc_reg[15:0], bus.mem_rdata};
               end
            end
            LAST: begin
               rvalid_reg <= 1'b1;
               if (misalign_reg) begin
                  rdata_reg <= '0;
                  err_reg   <= 1'b1;
               end else begin
                  rdata_reg <= {acc_reg, bus.mem_rdata};
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.fetch_rvalid = rvalid_reg;
   assign bus.fetch_rdata  = rdata_reg;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
   assign bus.fetch_err    = err_reg;
`else
   assign bus.fetch_err    = 1'b0;
`endif
endmodule
